// File: rtl/airlock_pkg.sv
// airlock_pkg: shared state encoding, motor direction constants and door helpers
package airlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPENING,
        ST_HOLD,
        ST_CLOSING
    } state_t;

    localparam logic MOTOR_OPEN  = 1'b1;
    localparam logic MOTOR_CLOSE = 1'b0;
    localparam int   TIMER_W     = 8;

    function automatic logic [1:0] door_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/airlock_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the door not last granted wins
module rr_arb2 (
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |pend;
        grant_idx   = (&pend) ? ~last_grant : pend[1];
    end

endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer: serves two interlocked doors with one shared motor,
// one door at a time, through open / hold / close phases.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 10,
    parameter int HOLD_CYCLES   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] obstacle,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       motor_sel,
    output logic [1:0] door_open,
    output logic [1:0] door_closed,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_grant_q, last_grant_d;
    logic [1:0]          pend_q, pend_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [1:0]          sel_mask, req_eff, pend_eff;
    logic                grant_valid, grant_idx;

    // A request for the door already being held open only extends the hold.
    always_comb begin
        sel_mask = door_mask(sel_q);
        req_eff  = (state_q == ST_HOLD) ? (req & ~sel_mask) : req;
        pend_eff = pend_q | req_eff;
    end

    rr_arb2 u_arb (
        .pend       (pend_eff),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        pend_d       = pend_eff;
        timer_d      = timer_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (grant_valid) begin
                    state_d      = ST_OPENING;
                    sel_d        = grant_idx;
                    last_grant_d = grant_idx;
                    pend_d       = pend_eff & ~door_mask(grant_idx);
                end
            end
            ST_OPENING: begin
                if (timer_q == TRAVEL_LAST) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end
            end
            ST_HOLD: begin
                if (req[sel_q] || timer_q == HOLD_LAST) begin
                    state_d = req[sel_q] ? ST_HOLD : ST_CLOSING;
                    timer_d = '0;
                end
            end
            ST_CLOSING: begin
                // An obstacle wins over expiry and forces a full re-open.
                if (obstacle[sel_q] || timer_q == TRAVEL_LAST) begin
                    state_d = obstacle[sel_q] ? ST_OPENING : ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            pend_q       <= 2'b00;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        busy        = state_q != ST_IDLE;
        motor_en    = state_q == ST_OPENING || state_q == ST_CLOSING;
        motor_dir   = state_q == ST_OPENING ? MOTOR_OPEN : MOTOR_CLOSE;
        motor_sel   = sel_q;
        door_open   = state_q == ST_HOLD ? sel_mask : 2'b00;
        door_closed = state_q == ST_IDLE ? 2'b11 : ~sel_mask;
    end

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb_airlock_sequencer: directed scenarios plus randomized run against a phase/countdown model
module tb_airlock_sequencer;

    localparam int T = 4;
    localparam int H = 6;
    localparam int P_IDLE = 0, P_OPEN = 1, P_HOLD = 2, P_CLOSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] obstacle = 2'b00;
    logic       motor_en, motor_dir, motor_sel, busy;
    logic [1:0] door_open, door_closed;

    int checks = 0;
    int errors = 0;

    int         m_phase = P_IDLE;
    int         m_left = 0;
    logic [1:0] m_pend = 2'b00;
    logic       m_sel = 1'b0;
    logic       m_last = 1'b1;

    airlock_sequencer #(.TRAVEL_CYCLES(T), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .obstacle   (obstacle),
        .motor_en   (motor_en),
        .motor_dir  (motor_dir),
        .motor_sel  (motor_sel),
        .door_open  (door_open),
        .door_closed(door_closed),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Each phase holds a count of cycles still to spend in it.
    task automatic model_step(input logic [1:0] r, input logic [1:0] o, input logic rs);
        logic [1:0] want;
        if (rs) begin
            m_phase = P_IDLE; m_left = 0; m_pend = 2'b00; m_sel = 1'b0; m_last = 1'b1;
            return;
        end
        want = m_pend | r;
        if (m_phase == P_HOLD) want[m_sel] = m_pend[m_sel];
        m_pend = want;
        case (m_phase)
            P_IDLE: if (want != 2'b00) begin
                m_sel = (want == 2'b11) ? ~m_last : want[1];
                m_last = m_sel;
                m_pend[m_sel] = 1'b0;
                m_phase = P_OPEN; m_left = T;
            end
            P_OPEN: if (m_left == 1) begin m_phase = P_HOLD; m_left = H; end else m_left--;
            P_HOLD: if (r[m_sel]) m_left = H;
                    else if (m_left == 1) begin m_phase = P_CLOSE; m_left = T; end
                    else m_left--;
            default: if (o[m_sel]) begin m_phase = P_OPEN; m_left = T; end
                     else if (m_left == 1) m_phase = P_IDLE;
                     else m_left--;
        endcase
    endtask

    task automatic cycle(input logic [1:0] r, input logic [1:0] o, input logic rs);
        req = r; obstacle = o; rst = rs;
        @(posedge clk);
        model_step(r, o, rs);
        #1;
    endtask

    task automatic run_until_idle(input int budget, output int n_op, output int n_hd,
                                  output int n_cl, output int n_bad, output bit timeout);
        int k = 0;
        n_op = 0; n_hd = 0; n_cl = 0; n_bad = 0;
        while (busy && k < budget) begin
            if (motor_en && motor_dir) n_op++;
            if (motor_en && !motor_dir) n_cl++;
            if (door_open != 2'b00) n_hd++;
            if (!door_closed[~motor_sel] || (door_open & door_closed) != 2'b00) n_bad++;
            cycle(2'b00, 2'b00, 1'b0);
            k++;
        end
        timeout = busy;
    endtask

    task automatic test_reset;
        cycle(2'b11, 2'b11, 1'b1);
        cycle(2'b00, 2'b00, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL reset_motor_en got=%b exp=0", motor_en); end
        checks++; if (motor_dir !== 1'b0) begin errors++; $display("FAIL reset_motor_dir got=%b exp=0", motor_dir); end
        checks++; if (motor_sel !== 1'b0) begin errors++; $display("FAIL reset_motor_sel got=%b exp=0", motor_sel); end
        checks++; if (door_open !== 2'b00) begin errors++; $display("FAIL reset_door_open got=%b exp=00", door_open); end
        checks++; if (door_closed !== 2'b11) begin errors++; $display("FAIL reset_door_closed got=%b exp=11", door_closed); end
        cycle(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_stays got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        int n_op, n_hd, n_cl, n_bad;
        bit to;
        cycle(2'b01, 2'b00, 1'b0);
        checks++; if ({busy, motor_en, motor_dir, motor_sel} !== 4'b1110) begin
            errors++; $display("FAIL single_start got=%b exp=1110", {busy, motor_en, motor_dir, motor_sel}); end
        run_until_idle(40, n_op, n_hd, n_cl, n_bad, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout busy=%b exp=0", busy); end
        checks++; if ({n_op, n_hd, n_cl} !== {T, H, T}) begin
            errors++; $display("FAIL single_phases got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_op, n_hd, n_cl, T, H, T); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL single_interlock got=%0d exp=0", n_bad); end
        checks++; if (door_closed !== 2'b11 || motor_en !== 1'b0) begin
            errors++; $display("FAIL single_end closed=%b en=%b exp=11/0", door_closed, motor_en); end
    endtask

    task automatic test_round_robin;
        int n_op, n_hd, n_cl, n_bad;
        bit to;
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b11, 2'b00, 1'b0);
        checks++; if (busy !== 1'b1 || motor_sel !== 1'b0) begin
            errors++; $display("FAIL rr_first got busy=%b sel=%b exp=1/0", busy, motor_sel); end
        run_until_idle(40, n_op, n_hd, n_cl, n_bad, to);
        checks++; if (to || busy !== 1'b0) begin errors++; $display("FAIL rr_a_done busy=%b exp=0", busy); end
        cycle(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b1 || motor_sel !== 1'b1) begin
            errors++; $display("FAIL rr_second got busy=%b sel=%b exp=1/1", busy, motor_sel); end
        run_until_idle(40, n_op, n_hd, n_cl, n_bad, to);
        checks++; if (to || {n_op, n_hd, n_cl} !== {T, H, T}) begin
            errors++; $display("FAIL rr_b_phases got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_op, n_hd, n_cl, T, H, T); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL rr_b_interlock got=%0d exp=0", n_bad); end
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_no_extra got=%b exp=0", busy); end
    endtask

    task automatic test_obstacle;
        int n_op, n_hd, n_cl, n_bad, k;
        bit to;
        cycle(2'b01, 2'b00, 1'b0);
        k = 0;
        while (!(motor_en && !motor_dir) && k < 40) begin cycle(2'b00, 2'b00, 1'b0); k++; end
        checks++; if (!(motor_en && !motor_dir)) begin errors++; $display("FAIL obs_reach_close got en=%b dir=%b exp=1/0", motor_en, motor_dir); end
        cycle(2'b00, 2'b10, 1'b0);
        checks++; if ({motor_en, motor_dir} !== 2'b10) begin
            errors++; $display("FAIL obs_other_door_ignored got=%b exp=10", {motor_en, motor_dir}); end
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b01, 1'b0);
        checks++; if ({motor_en, motor_dir} !== 2'b11) begin
            errors++; $display("FAIL obs_reopen got=%b exp=11", {motor_en, motor_dir}); end
        run_until_idle(40, n_op, n_hd, n_cl, n_bad, to);
        checks++; if (to || {n_op, n_hd, n_cl} !== {T, H, T}) begin
            errors++; $display("FAIL obs_phases got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_op, n_hd, n_cl, T, H, T); end
    endtask

    task automatic test_hold_extend;
        int n_op, n_hd, n_cl, n_bad, k, n_busy;
        bit to;
        cycle(2'b01, 2'b00, 1'b0);
        k = 0;
        while (door_open !== 2'b01 && k < 40) begin cycle(2'b00, 2'b00, 1'b0); k++; end
        for (int i = 0; i < 4; i++) cycle(2'b00, 2'b00, 1'b0);
        checks++; if (door_open !== 2'b01) begin errors++; $display("FAIL hold_cycle5 got=%b exp=01", door_open); end
        cycle(2'b01, 2'b00, 1'b0);
        run_until_idle(40, n_op, n_hd, n_cl, n_bad, to);
        checks++; if (to || 5 + n_hd !== 11 || n_cl !== T) begin
            errors++; $display("FAIL hold_extend got hold=%0d close=%0d exp=11/%0d", 5 + n_hd, n_cl, T); end
        n_busy = 0;
        for (int i = 0; i < 5; i++) begin cycle(2'b00, 2'b00, 1'b0); if (busy) n_busy++; end
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL hold_no_reserve got=%0d exp=0", n_busy); end
    endtask

    task automatic test_reset_mid;
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b10, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 1'b0);
        checks++; if ({motor_en, motor_dir, motor_sel} !== 3'b111) begin
            errors++; $display("FAIL rstmid_b_opening got=%b exp=111", {motor_en, motor_dir, motor_sel}); end
        cycle(2'b00, 2'b00, 1'b1);
        checks++; if (motor_en !== 1'b0 || door_closed !== 2'b11 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort got en=%b closed=%b busy=%b exp=0/11/0", motor_en, door_closed, busy); end
        cycle(2'b00, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_pend_cleared got=%b exp=0", busy); end
        cycle(2'b11, 2'b00, 1'b0);
        checks++; if (busy !== 1'b1 || motor_sel !== 1'b0) begin
            errors++; $display("FAIL rstmid_grant_a got busy=%b sel=%b exp=1/0", busy, motor_sel); end
    endtask

    task automatic test_random;
        logic [1:0] r, o, exp_open, exp_closed;
        logic       rs;
        logic [7:0] exp, got;
        cycle(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            r  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            o  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            rs = ($urandom_range(0, 249) == 0);
            cycle(r, o, rs);
            exp_open   = (m_phase == P_HOLD) ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
            exp_closed = (m_phase == P_IDLE) ? 2'b11 : (m_sel ? 2'b01 : 2'b10);
            exp = {m_phase != P_IDLE, m_phase == P_OPEN || m_phase == P_CLOSE, m_phase == P_OPEN,
                   m_sel, exp_open, exp_closed};
            got = {busy, motor_en, motor_dir, motor_sel, door_open, door_closed};
            checks++; if (got !== exp) begin
                errors++; $display("FAIL random_cycle%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_obstacle;
        test_hold_extend;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
